// File: rtl/mem_access_splitter.sv
// Splits core byte/half/word loads and stores into right-justified RAM transactions.
// Build option MEM_SPLIT_MISALIGN_EN enables splitting of accesses that cross a 4-byte boundary.
module mem_access_splitter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              ramclk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              resp_valid,
    output logic [ADDR_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_io_addr,
    output logic              mem_io_read,
    output logic              mem_io_write,
    output logic [ADDR_W-1:0] mem_io_wdata,
    output logic [1:0]        io_byte_size,
    input  logic [ADDR_W-1:0] mem_io_rdata,
    input  logic              mem_io_ready
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef MEM_SPLIT_MISALIGN_EN
    typedef enum logic [2:0] {IDLE, ACC1, GAP, ACC2, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC1, RESP} state_t;
`endif

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic              uns_q, uns_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        n1_q, n1_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [ADDR_W-1:0] mwdata_q, mwdata_d;
    logic [1:0]        msize_q, msize_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;
    logic [ADDR_W-1:0] rdata_q, rdata_d;
`ifdef MEM_SPLIT_MISALIGN_EN
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] merge_q, merge_d;
    logic [2:0]        n2;
`endif

    logic [2:0]        n_req, room, n1_req;
    logic              reject, timeout;
    logic [ADDR_W-1:0] acc_m;

    function automatic logic [ADDR_W-1:0] keep_bytes(input logic [ADDR_W-1:0] v, input logic [2:0] k);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (b < 32'(k)) r[8*b +: 8] = v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] extend(input logic [ADDR_W-1:0] m, input logic [2:0] n, input logic u);
        logic [ADDR_W-1:0] r;
        r = m;
        case (n)
            3'd1:    r = {{(ADDR_W-8){~u & m[7]}}, m[7:0]};
            3'd2:    r = {{(ADDR_W-16){~u & m[15]}}, m[15:0]};
            default: r = m;
        endcase
        return r;
    endfunction

    always_comb begin
        case (req_size)
            2'd0:    n_req = 3'd1;
            2'd1:    n_req = 3'd2;
            2'd2:    n_req = 3'd4;
            default: n_req = 3'd0;
        endcase
        room   = 3'd4 - {1'b0, req_addr[1:0]};
        n1_req = (n_req < room) ? n_req : room;
    end

`ifdef MEM_SPLIT_MISALIGN_EN
    assign reject = (req_size == 2'd3);
    assign n2     = n_q - n1_q;
`else
    assign reject = (req_size == 2'd3) || (n_req > room);
`endif

    assign timeout = (TIMEOUT_CYCLES != 0) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        uns_d    = uns_q;
        n_d      = n_q;
        n1_d     = n1_q;
        tcnt_d   = tcnt_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        msize_d  = msize_q;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        rdata_d  = '0;
        acc_m    = '0;
`ifdef MEM_SPLIT_MISALIGN_EN
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    uns_d   = req_unsigned;
                    n_d     = n_req;
                    n1_d    = n1_req;
                    tcnt_d  = '0;
`ifdef MEM_SPLIT_MISALIGN_EN
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    merge_d = '0;
`endif
                    if (reject) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end else begin
                        state_d  = ACC1;
                        rd_d     = ~req_write;
                        wr_d     = req_write;
                        maddr_d  = req_addr;
                        msize_d  = n1_req[1:0];
                        mwdata_d = keep_bytes(req_wdata, n1_req);
                    end
                end
            end
            ACC1: begin
                if (mem_io_ready) begin
                    rd_d  = 1'b0;
                    wr_d  = 1'b0;
                    acc_m = keep_bytes(mem_io_rdata, n1_q);
`ifdef MEM_SPLIT_MISALIGN_EN
                    merge_d = acc_m;
                    if (n2 != 3'd0) begin
                        state_d = GAP;
                    end else
`endif
                    begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rdata_d  = write_q ? '0 : extend(acc_m, n_q, uns_q);
                    end
                end else if (timeout) begin
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
`ifdef MEM_SPLIT_MISALIGN_EN
            GAP: begin
                // Strobes stay low here so the RAM sees the second half as a new request.
                state_d  = ACC2;
                tcnt_d   = '0;
                rd_d     = ~write_q;
                wr_d     = write_q;
                maddr_d  = addr_q + ADDR_W'(n1_q);
                msize_d  = n2[1:0];
                mwdata_d = keep_bytes(wdata_q >> (8 * n1_q), n2);
            end
            ACC2: begin
                if (mem_io_ready) begin
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    acc_m    = merge_q | (keep_bytes(mem_io_rdata, n2) << (8 * n1_q));
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = write_q ? '0 : extend(acc_m, n_q, uns_q);
                end else if (timeout) begin
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
`endif
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ramclk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            uns_q    <= 1'b0;
            n_q      <= '0;
            n1_q     <= '0;
            tcnt_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            msize_q  <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
`ifdef MEM_SPLIT_MISALIGN_EN
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            uns_q    <= uns_d;
            n_q      <= n_d;
            n1_q     <= n1_d;
            tcnt_q   <= tcnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            msize_q  <= msize_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
`ifdef MEM_SPLIT_MISALIGN_EN
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
`endif
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = rvalid_q;
    assign resp_rdata   = rdata_q;
    assign resp_err     = rerr_q;
    assign mem_io_addr  = maddr_q;
    assign mem_io_read  = rd_q;
    assign mem_io_write = wr_q;
    assign mem_io_wdata = mwdata_q;
    assign io_byte_size = msize_q;

endmodule

// File: tb/tb_mem_access_splitter.sv
// Scoreboard bench for mem_access_splitter; split-path expectations follow MEM_SPLIT_MISALIGN_EN.
module tb_mem_access_splitter;

    logic        ramclk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_io_addr, mem_io_wdata;
    logic        mem_io_read, mem_io_write;
    logic [1:0]  io_byte_size;
    logic [31:0] mem_io_rdata;
    logic        mem_io_ready;

    mem_access_splitter #(.ADDR_W(32), .TIMEOUT_CYCLES(64)) dut (
        .ramclk(ramclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_io_addr(mem_io_addr), .mem_io_read(mem_io_read), .mem_io_write(mem_io_write),
        .mem_io_wdata(mem_io_wdata), .io_byte_size(io_byte_size),
        .mem_io_rdata(mem_io_rdata), .mem_io_ready(mem_io_ready)
    );

    always #5 ramclk = ~ramclk;

    typedef struct { logic wr; logic [31:0] addr; logic [1:0] size; logic [31:0] wdata; } acc_t;
    typedef struct { logic [31:0] rdata; logic err; } rsp_t;

    acc_t        exp_acc[$];
    rsp_t        exp_rsp[$];
    logic [31:0] ram_rd[$];
    logic        ram_hang = 1'b0;
    int          total = 0, bad = 0, cyc = 0;
    int          rise_cyc = 0, fall_cyc = -100, last_gap = 0, last_high = 0;
    logic        strobe_prev = 1'b0;

    always @(posedge ramclk) cyc <= cyc + 1;

    // RAM model: one-cycle ready pulse per strobe, read data popped from ram_rd.
    always @(posedge ramclk or negedge rst) begin
        if (!rst) begin
            mem_io_ready <= 1'b0;
            mem_io_rdata <= '0;
        end else begin
            mem_io_ready <= 1'b0;
            if ((mem_io_read || mem_io_write) && !mem_io_ready && !ram_hang) begin
                mem_io_ready <= 1'b1;
                if (mem_io_read) begin
                    if (ram_rd.size() > 0) mem_io_rdata <= ram_rd.pop_front();
                    else                   mem_io_rdata <= '0;
                end
            end
        end
    end

    // Each strobe rise is checked against the next expected access.
    always @(negedge ramclk) begin
        logic s;
        acc_t e;
        s = mem_io_read | mem_io_write;
        if (s && !strobe_prev) begin
            last_gap = cyc - fall_cyc;
            rise_cyc = cyc;
            total++;
            if (exp_acc.size() == 0) begin
                bad++;
                $display("FAIL access_unexpected: got wr=%0d addr=%h size=%0d want no access",
                         mem_io_write, mem_io_addr, io_byte_size);
            end else begin
                e = exp_acc.pop_front();
                if (mem_io_write !== e.wr || mem_io_read !== ~e.wr || mem_io_addr !== e.addr ||
                    io_byte_size !== e.size || (e.wr && mem_io_wdata !== e.wdata)) begin
                    bad++;
                    $display("FAIL access: got wr=%0d addr=%h size=%0d wdata=%h want wr=%0d addr=%h size=%0d wdata=%h",
                             mem_io_write, mem_io_addr, io_byte_size, mem_io_wdata, e.wr, e.addr, e.size, e.wdata);
                end
            end
        end
        if (!s && strobe_prev) begin
            fall_cyc  = cyc;
            last_high = cyc - rise_cyc;
        end
        strobe_prev = s;
    end

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic un, output int t0);
        @(negedge ramclk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge ramclk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        req_size = sz; req_unsigned = un;
        t0 = cyc;
        @(posedge ramclk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic got, output logic [31:0] rd, output logic er, output int tc);
        got = 1'b0; rd = '0; er = 1'b0; tc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge ramclk);
            if (resp_valid) begin
                got = 1'b1; rd = resp_rdata; er = resp_err; tc = cyc;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_resp: got ready=%0d valid=%0d err=%0d rdata=%h want 1 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        total++;
        if (mem_io_read !== 1'b0 || mem_io_write !== 1'b0 || mem_io_addr !== 32'h0 ||
            mem_io_wdata !== 32'h0 || io_byte_size !== 2'd0) begin
            bad++;
            $display("FAIL reset_mem: got rd=%0d wr=%0d addr=%h wdata=%h size=%0d want all 0",
                     mem_io_read, mem_io_write, mem_io_addr, mem_io_wdata, io_byte_size);
        end
        @(negedge ramclk); rst = 1'b1;
        repeat (2) @(negedge ramclk);
    endtask

    task automatic test_aligned_load;
        int t0, tc; logic got, er; logic [31:0] rd; rsp_t e;
        exp_acc.push_back('{1'b0, 32'h100, 2'd0, 32'h0});
        exp_rsp.push_back('{32'h12345678, 1'b0});
        ram_rd.push_back(32'h12345678);
        do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, t0);
        wait_resp(got, rd, er, tc);
        e = exp_rsp.pop_front();
        total++;
        if (!got || rd !== e.rdata || er !== e.err) begin
            bad++;
            $display("FAIL aligned_load: got valid=%0d rdata=%h err=%0d want rdata=%h err=%0d", got, rd, er, e.rdata, e.err);
        end
        total++;
        if (tc - t0 != 3) begin
            bad++;
            $display("FAIL aligned_latency: got %0d cycles want 3", tc - t0);
        end
    endtask

    typedef struct { logic [31:0] addr; logic [1:0] sz; logic un; logic [31:0] ram; logic [1:0] esz; logic [31:0] erd; } ld_t;

    task automatic test_ext_loads;
        ld_t rows[5];
        int t0, tc; logic got, er; logic [31:0] rd; rsp_t e;
        rows = '{'{32'h2, 2'd0, 1'b0, 32'h00000080, 2'd1, 32'hFFFFFF80},
                 '{32'h2, 2'd0, 1'b1, 32'h00000080, 2'd1, 32'h00000080},
                 '{32'h6, 2'd1, 1'b0, 32'h00008001, 2'd2, 32'hFFFF8001},
                 '{32'h6, 2'd1, 1'b1, 32'hFFFF8001, 2'd2, 32'h00008001},
                 '{32'h3, 2'd0, 1'b0, 32'h1234567F, 2'd1, 32'h0000007F}};
        foreach (rows[i]) begin
            exp_acc.push_back('{1'b0, rows[i].addr, rows[i].esz, 32'h0});
            exp_rsp.push_back('{rows[i].erd, 1'b0});
            ram_rd.push_back(rows[i].ram);
            do_req(1'b0, rows[i].addr, 32'h0, rows[i].sz, rows[i].un, t0);
            wait_resp(got, rd, er, tc);
            e = exp_rsp.pop_front();
            total++;
            if (!got || rd !== e.rdata || er !== e.err) begin
                bad++;
                $display("FAIL ext_load[%0d]: got valid=%0d rdata=%h err=%0d want rdata=%h err=%0d", i, got, rd, er, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_stores;
        int t0, tc; logic got, er; logic [31:0] rd; rsp_t e;
        exp_acc.push_back('{1'b1, 32'h200, 2'd0, 32'hCAFEF00D});
        exp_acc.push_back('{1'b1, 32'h3, 2'd1, 32'h0000005A});
        for (int i = 0; i < 2; i++) begin
            exp_rsp.push_back('{32'h0, 1'b0});
            if (i == 0) do_req(1'b1, 32'h200, 32'hCAFEF00D, 2'd2, 1'b0, t0);
            else        do_req(1'b1, 32'h3, 32'hFFFFFF5A, 2'd0, 1'b0, t0);
            wait_resp(got, rd, er, tc);
            e = exp_rsp.pop_front();
            total++;
            if (!got || rd !== e.rdata || er !== e.err) begin
                bad++;
                $display("FAIL store[%0d]: got valid=%0d rdata=%h err=%0d want rdata=%h err=%0d", i, got, rd, er, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_split_store;
        int t0, tc; logic got, er; logic [31:0] rd; rsp_t e;
`ifdef MEM_SPLIT_MISALIGN_EN
        exp_acc.push_back('{1'b1, 32'h103, 2'd1, 32'h000000EF});
        exp_acc.push_back('{1'b1, 32'h104, 2'd1, 32'h000000BE});
        exp_rsp.push_back('{32'h0, 1'b0});
`else
        exp_rsp.push_back('{32'h0, 1'b1});
`endif
        do_req(1'b1, 32'h103, 32'h0000BEEF, 2'd1, 1'b0, t0);
        wait_resp(got, rd, er, tc);
        e = exp_rsp.pop_front();
        total++;
        if (!got || rd !== e.rdata || er !== e.err) begin
            bad++;
            $display("FAIL split_store: got valid=%0d rdata=%h err=%0d want rdata=%h err=%0d", got, rd, er, e.rdata, e.err);
        end
`ifdef MEM_SPLIT_MISALIGN_EN
        total++;
        if (last_gap != 1) begin
            bad++;
            $display("FAIL split_gap: got %0d idle cycles want 1", last_gap);
        end
`endif
    endtask

    task automatic test_split_load;
        int t0, tc; logic got, er; logic [31:0] rd; rsp_t e;
`ifdef MEM_SPLIT_MISALIGN_EN
        exp_acc.push_back('{1'b0, 32'h102, 2'd2, 32'h0});
        exp_acc.push_back('{1'b0, 32'h104, 2'd2, 32'h0});
        ram_rd.push_back(32'h00001234);
        ram_rd.push_back(32'h00005678);
        exp_rsp.push_back('{32'h56781234, 1'b0});
`else
        exp_rsp.push_back('{32'h0, 1'b1});
`endif
        do_req(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, t0);
        wait_resp(got, rd, er, tc);
        e = exp_rsp.pop_front();
        total++;
        if (!got || rd !== e.rdata || er !== e.err) begin
            bad++;
            $display("FAIL split_load: got valid=%0d rdata=%h err=%0d want rdata=%h err=%0d", got, rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_wrap;
        int t0, tc; logic got, er; logic [31:0] rd; rsp_t e;
`ifdef MEM_SPLIT_MISALIGN_EN
        exp_acc.push_back('{1'b0, 32'hFFFFFFFF, 2'd1, 32'h0});
        exp_acc.push_back('{1'b0, 32'h00000000, 2'd1, 32'h0});
        ram_rd.push_back(32'hFFFFFFAB);
        ram_rd.push_back(32'h123456CD);
        exp_rsp.push_back('{32'hFFFFCDAB, 1'b0});
`else
        exp_rsp.push_back('{32'h0, 1'b1});
`endif
        do_req(1'b0, 32'hFFFFFFFF, 32'h0, 2'd1, 1'b0, t0);
        wait_resp(got, rd, er, tc);
        e = exp_rsp.pop_front();
        total++;
        if (!got || rd !== e.rdata || er !== e.err) begin
            bad++;
            $display("FAIL wrap_load: got valid=%0d rdata=%h err=%0d want rdata=%h err=%0d", got, rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_reserved;
        int t0, tc; logic got, er; logic [31:0] rd; rsp_t e;
        exp_rsp.push_back('{32'h0, 1'b1});
        do_req(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, t0);
        wait_resp(got, rd, er, tc);
        e = exp_rsp.pop_front();
        total++;
        if (!got || rd !== e.rdata || er !== e.err || tc - t0 != 1) begin
            bad++;
            $display("FAIL reserved: got valid=%0d rdata=%h err=%0d lat=%0d want rdata=%h err=%0d lat=1",
                     got, rd, er, tc - t0, e.rdata, e.err);
        end
    endtask

    task automatic test_timeout;
        int t0, tc; logic got, er; logic [31:0] rd; rsp_t e;
        ram_hang = 1'b1;
        exp_acc.push_back('{1'b0, 32'h300, 2'd0, 32'h0});
        exp_rsp.push_back('{32'h0, 1'b1});
        do_req(1'b0, 32'h300, 32'h0, 2'd2, 1'b0, t0);
        // Offer a second request while busy; it must not start an access.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h400; req_size = 2'd2;
        wait_resp(got, rd, er, tc);
        req_valid = 1'b0;
        ram_hang = 1'b0;
        e = exp_rsp.pop_front();
        total++;
        if (!got || rd !== e.rdata || er !== e.err) begin
            bad++;
            $display("FAIL timeout_resp: got valid=%0d rdata=%h err=%0d want rdata=%h err=%0d", got, rd, er, e.rdata, e.err);
        end
        @(negedge ramclk);
        total++;
        if (last_high != 64) begin
            bad++;
            $display("FAIL timeout_strobe: got %0d cycles high want 64", last_high);
        end
        exp_acc.push_back('{1'b0, 32'h104, 2'd0, 32'h0});
        exp_rsp.push_back('{32'hA5A5A5A5, 1'b0});
        ram_rd.push_back(32'hA5A5A5A5);
        do_req(1'b0, 32'h104, 32'h0, 2'd2, 1'b0, t0);
        wait_resp(got, rd, er, tc);
        e = exp_rsp.pop_front();
        total++;
        if (!got || rd !== e.rdata || er !== e.err) begin
            bad++;
            $display("FAIL after_timeout: got valid=%0d rdata=%h err=%0d want rdata=%h err=%0d", got, rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_reset_mid;
        int t0, seen; logic ok;
`ifdef MEM_SPLIT_MISALIGN_EN
        exp_acc.push_back('{1'b1, 32'h203, 2'd1, 32'h00000022});
        exp_acc.push_back('{1'b1, 32'h204, 2'd1, 32'h00000011});
        do_req(1'b1, 32'h203, 32'h00001122, 2'd1, 1'b0, t0);
`else
        exp_acc.push_back('{1'b1, 32'h204, 2'd0, 32'h11223344});
        do_req(1'b1, 32'h204, 32'h11223344, 2'd2, 1'b0, t0);
`endif
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ramclk);
            if (mem_io_write && mem_io_addr == 32'h204) ok = 1'b1;
        end
        ram_hang = 1'b1;
        @(negedge ramclk);
        rst = 1'b0;
        #1;
        total++;
        if (!ok || mem_io_write !== 1'b0 || mem_io_read !== 1'b0 || mem_io_addr !== 32'h0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: got reached=%0d wr=%0d rd=%0d addr=%h ready=%0d want 1 0 0 0 1",
                     ok, mem_io_write, mem_io_read, mem_io_addr, req_ready);
        end
        seen = 0;
        repeat (4) begin
            @(negedge ramclk);
            if (resp_valid) seen++;
        end
        rst = 1'b1;
        ram_hang = 1'b0;
        @(negedge ramclk);
        if (resp_valid) seen++;
        total++;
        if (seen != 0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got resp_pulses=%0d ready=%0d want 0 1", seen, req_ready);
        end
    endtask

    task automatic test_final;
        repeat (3) @(negedge ramclk);
        total++;
        if (exp_acc.size() != 0 || exp_rsp.size() != 0) begin
            bad++;
            $display("FAIL leftover: got acc=%0d rsp=%0d pending want 0 0", exp_acc.size(), exp_rsp.size());
        end
    endtask

    initial begin
        test_reset;
        test_aligned_load;
        test_ext_loads;
        test_stores;
        test_split_store;
        test_split_load;
        test_wrap;
        test_reserved;
        test_timeout;
        test_reset_mid;
        test_final;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_splitter.md
Name: mem_access_splitter

Overview:
- Sits directly upstream of the off-chip/Digital RAM port. Drives mem_io_addr/read/write/wdata/io_byte_size and consumes mem_io_ready/mem_io_rdata.
- Accepts one core load/store at a time: byte, half or word, at any byte address.
- Accesses that cross a 4-byte boundary are split into two right-justified RAM transactions. The two read halves are merged, and load data is sign- or zero-extended.
- A wait timeout turns a hung RAM into an error response.

Parameters:
- ADDR_W, 32, address/data width (equals `XLEN).
- TIMEOUT_CYCLES, 64, maximum cycles to wait for mem_io_ready per transaction; 0 disables the timeout.

Ports:
- ramclk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  splitter idle, request accepted when valid&ready
- req_write  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  ADDR_W  store data, right-justified
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (error)
- req_unsigned  in  1  zero-extend load data
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  ADDR_W  extended load data (0 for stores)
- resp_err  out  1  valid with resp_valid: timeout, reserved size, or misalign-disabled
- mem_io_addr  out  ADDR_W  RAM byte address
- mem_io_read  out  1  RAM read strobe
- mem_io_write  out  1  RAM write strobe
- mem_io_wdata  out  ADDR_W  RAM write data, low bytes valid
- io_byte_size  out  2  bytes in transfer: 1,2,3; 0 means 4
- mem_io_rdata  in  ADDR_W  RAM read data, low bytes valid
- mem_io_ready  in  1  RAM one-cycle completion pulse

Behaviour:
- Reset values: req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_io_read=0; mem_io_write=0; mem_io_addr=0; mem_io_wdata=0; io_byte_size=0. FSM=IDLE.
- States: IDLE, ACC1, GAP, ACC2, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch all request fields and compute n = 1/2/4 bytes and off = addr[1:0].
  - n1 = min(n, 4-off); n2 = n-n1.
  - Reserved size: go to RESP with err=1 and issue no RAM access.
  - Otherwise go to ACC1.
- ACC1:
  - Drive mem_io_addr=addr, io_byte_size=n1 (4 encoded as 0), wdata=req_wdata low n1 bytes (upper bytes zero).
  - Assert read or write. Strobes are registered, so they rise the cycle after accept.
  - On mem_io_ready: capture mem_io_rdata[8*n1-1:0] into merge bits [8*n1-1:0] and deassert the strobe. Go to GAP if n2>0, else RESP.
- GAP:
  - Strobes low for exactly one cycle, so the RAM sees a fresh request.
  - Go to ACC2.
- ACC2:
  - Drive mem_io_addr=addr+n1, io_byte_size=n2, wdata=req_wdata>>(8*n1).
  - On ready: place mem_io_rdata low n2 bytes at merge[8*n1 +: 8*n2]. Go to RESP.
- RESP:
  - resp_valid=1 for one cycle.
  - resp_rdata = merge masked to n bytes, sign-extended from bit 8n-1 unless req_unsigned; 0 for stores.
  - Next state IDLE, with req_ready=1 in the following cycle.
- Latency, aligned access with a 1-cycle RAM: accept at T0, strobe T1, ready T2, resp_valid T3.
- Timeout:
  - A counter resets at each ACCx entry and increments while waiting.
  - When it reaches TIMEOUT_CYCLES: drop the strobe, go to RESP with err=1 and rdata=0. ACC2 is skipped if the timeout hits in ACC1.
- mem_io_ready while not in ACC1/ACC2 is ignored.
- req_valid while busy is not accepted; there is no queuing.
- Address wrap: addr+n1 wraps modulo 2^ADDR_W.
- Reset mid-operation: all outputs return to their reset values immediately, the partial store is not completed, and no response is issued.

Optional Feature:
- Macro: MEM_SPLIT_MISALIGN_EN.
- Defined: boundary-crossing accesses are split as described above.
- Undefined:
  - Any access with off+n>4 goes IDLE→RESP with resp_err=1, resp_rdata=0 and no RAM strobe.
  - GAP and ACC2 are not synthesised.
  - Non-crossing unaligned accesses (e.g. byte at 0x3) still run as single transactions.

Test Plan:
- Aligned word load, addr 0x100, RAM returns 0x12345678 → one read, io_byte_size=0, resp_rdata=0x12345678, resp_err=0, resp_valid at T3.
- Signed byte load, addr 0x2, RAM returns 0x00000080 → io_byte_size=1, resp_rdata=0xFFFFFF80; with req_unsigned=1 → 0x00000080.
- Misaligned half store, addr 0x103, wdata 0xBEEF → write addr 0x103 size 1 wdata 0xEF; one GAP cycle with strobes low; write addr 0x104 size 1 wdata 0xBE; resp_err=0.
- Misaligned word load, addr 0x102, RAM returns 0x00001234 then 0x00005678 → accesses (0x102, size 2), (0x104, size 2), resp_rdata=0x56781234. With the macro undefined → no strobe, resp_err=1.
- RAM never asserts ready, TIMEOUT_CYCLES=64 → strobe drops after 64 wait cycles, resp_valid with resp_err=1, rdata=0; next request is accepted normally.
- rst low during ACC2 of a split store → strobes drop asynchronously, no resp_valid, req_ready=1 after reset release.
